// File: rtl/slowfil_feeder.sv
// Upstream driver for a single-multiplier slow FIR: paces buffered samples
// into the filter and runs reset-then-stream coefficient reloads on request.
module slowfil_feeder #(
    parameter int IW      = 16,
    parameter int TW      = 16,
    parameter int LGNTAPS = 7,
    parameter int NTAPS   = 110,
    parameter int MINGAP  = NTAPS,
    parameter int LGFIFO  = 4
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_s_valid,
    output logic              o_s_ready,
    input  logic [IW-1:0]     i_s_data,
    input  logic              i_coef_start,
    input  logic              i_c_valid,
    output logic              o_c_ready,
    input  logic [TW-1:0]     i_c_data,
    output logic              o_fil_reset,
    output logic              o_tap_wr,
    output logic [TW-1:0]     o_tap,
    output logic              o_ce,
    output logic [IW-1:0]     o_sample,
    output logic              o_loading,
    output logic [LGFIFO:0]   o_fill
);

    localparam int DEPTH = 1 << LGFIFO;
    localparam int GW    = $clog2(MINGAP + 3);

    localparam logic [LGFIFO:0]  FULL     = (LGFIFO+1)'(DEPTH);
    localparam logic [LGNTAPS:0] LAST_TAP = (LGNTAPS+1)'(NTAPS - 1);
    localparam logic [GW-1:0]    GAP_INIT = GW'(MINGAP);
    localparam logic [GW-1:0]    GAP_LOAD = GW'(2);

    typedef enum logic [1:0] {
        S_RUN,
        S_RST,
        S_LOAD
    } state_t;

    state_t state, state_nxt;

    logic [IW-1:0]     mem [DEPTH];
    logic [LGFIFO-1:0] wr_ptr, rd_ptr;
    logic [LGFIFO:0]   fill;
    logic [GW-1:0]     gap_cnt;
    logic [LGNTAPS:0]  tap_cnt;

    logic wr_en, issue, c_accept, last_tap;

    assign o_s_ready   = (fill < FULL);
    assign o_c_ready   = (state == S_LOAD);
    assign o_fil_reset = (state == S_RST);
    assign o_loading   = (state != S_RUN);
    assign o_fill      = fill;

    assign wr_en    = i_s_valid && o_s_ready;
    // The start edge itself already suppresses issue so no strobe races the filter reset.
    assign issue    = (state == S_RUN) && !i_coef_start && (fill != '0) && (gap_cnt == '0);
    assign c_accept = i_c_valid && o_c_ready;
    assign last_tap = c_accept && (tap_cnt == LAST_TAP);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) state <= S_RUN;
        else         state <= state_nxt;
    end

    // NOTE: next-state defaults to the current state before the case, so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt = state;
        case (state)
            S_RUN:   if (i_coef_start) state_nxt = S_RST;
            S_RST:   state_nxt = S_LOAD;
            S_LOAD:  if (last_tap) state_nxt = S_RUN;
            default: state_nxt = S_RUN;
        endcase
    end

    // NOTE: the sample storage has no reset; fill and pointers alone define which entries are valid.
    always_ff @(posedge i_clk) begin
        if (wr_en) mem[wr_ptr] <= i_s_data;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (issue) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, issue})
                2'b10:   fill <= fill + 1'b1;
                2'b01:   fill <= fill - 1'b1;
                default: fill <= fill;
            endcase
        end
    end

    // Post-load gap of 2 keeps the first sample strobe clear of the final tap write.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_ce     <= 1'b0;
            o_sample <= '0;
            gap_cnt  <= '0;
        end else begin
            o_ce <= issue;
            if (issue) begin
                o_sample <= mem[rd_ptr];
                gap_cnt  <= GAP_INIT;
            end else if (last_tap) begin
                gap_cnt <= GAP_LOAD;
            end else if (gap_cnt != '0) begin
                gap_cnt <= gap_cnt - 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_tap_wr <= 1'b0;
            o_tap    <= '0;
            tap_cnt  <= '0;
        end else begin
            o_tap_wr <= c_accept;
            if (state == S_RST) begin
                tap_cnt <= '0;
            end else if (c_accept) begin
                o_tap   <= i_c_data;
                tap_cnt <= tap_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_slowfil_feeder.sv
// Directed bench for slowfil_feeder: sample pacing, FIFO limits, coefficient
// reloads, async reset mid-load and ignored requests.
module tb_slowfil_feeder;

    logic        clk;
    logic        i_reset;
    logic        i_s_valid;
    logic        o_s_ready;
    logic [15:0] i_s_data;
    logic        i_coef_start;
    logic        i_c_valid;
    logic        o_c_ready;
    logic [15:0] i_c_data;
    logic        o_fil_reset;
    logic        o_tap_wr;
    logic [15:0] o_tap;
    logic        o_ce;
    logic [15:0] o_sample;
    logic        o_loading;
    logic [4:0]  o_fill;

    int checks = 0;
    int passed = 0;
    int cyc    = 0;

    logic [15:0] ce_q[$];
    int          ce_cyc[$];
    logic [15:0] tap_q[$];
    int          last_tap_cyc;
    int          fil_rst_n;
    int          max_fill;

    slowfil_feeder dut (
        .i_clk        (clk),
        .i_reset      (i_reset),
        .i_s_valid    (i_s_valid),
        .o_s_ready    (o_s_ready),
        .i_s_data     (i_s_data),
        .i_coef_start (i_coef_start),
        .i_c_valid    (i_c_valid),
        .o_c_ready    (o_c_ready),
        .i_c_data     (i_c_data),
        .o_fil_reset  (o_fil_reset),
        .o_tap_wr     (o_tap_wr),
        .o_tap        (o_tap),
        .o_ce         (o_ce),
        .o_sample     (o_sample),
        .o_loading    (o_loading),
        .o_fill       (o_fill)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge, then record what the filter side saw in that cycle.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (o_ce === 1'b1) begin
            ce_q.push_back(o_sample);
            ce_cyc.push_back(cyc);
        end
        if (o_tap_wr === 1'b1) begin
            tap_q.push_back(o_tap);
            last_tap_cyc = cyc;
        end
        if (o_fil_reset === 1'b1) fil_rst_n++;
        if (int'(o_fill) > max_fill) max_fill = int'(o_fill);
    endtask

    task automatic clear_log();
        ce_q.delete();
        ce_cyc.delete();
        tap_q.delete();
        last_tap_cyc = 0;
        fil_rst_n    = 0;
        max_fill     = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Request a reload and stream coefficients 0..109; optionally re-request mid-load.
    task automatic do_load(input bit toggle, input int restart_at);
        int  drv;
        int  n;
        bit  restarted;
        drv = 0;
        n = 0;
        restarted = 1'b0;
        i_coef_start = 1'b1;
        tick();
        i_coef_start = 1'b0;
        while (tap_q.size() < 110 && n < 600) begin
            i_c_valid = (drv < 110) && (!toggle || (n % 2 == 0));
            i_c_data  = i_c_valid ? 16'(drv) : 16'hBEEF;
            if (restart_at >= 0 && !restarted && drv == restart_at) begin
                i_coef_start = 1'b1;
                restarted = 1'b1;
            end else begin
                i_coef_start = 1'b0;
            end
            if (i_c_valid && o_c_ready) drv++;
            tick();
            n++;
        end
        i_c_valid    = 1'b0;
        i_c_data     = '0;
        i_coef_start = 1'b0;
    endtask

    task automatic test_reset();
        i_reset = 1'b0;
        i_s_valid = 1'b0; i_s_data = '0;
        i_coef_start = 1'b0; i_c_valid = 1'b0; i_c_data = '0;
        #1 i_reset = 1'b1;
        #1;
        checks++; if (o_s_ready !== 1'b1) $display("FAIL reset_s_ready: got %b expected 1", o_s_ready); else passed++;
        checks++; if ({o_ce, o_tap_wr, o_fil_reset, o_loading, o_c_ready} !== 5'b0)
            $display("FAIL reset_strobes: got %b expected 00000", {o_ce, o_tap_wr, o_fil_reset, o_loading, o_c_ready});
        else passed++;
        i_s_valid = 1'b1; i_s_data = 16'h5555; i_coef_start = 1'b1; i_c_valid = 1'b1;
        tick();
        tick();
        checks++; if (o_fill !== 5'd0) $display("FAIL reset_edges_fill: got %0d expected 0", o_fill); else passed++;
        checks++; if ({o_loading, o_tap, o_sample} !== 33'b0)
            $display("FAIL reset_edges_outputs: got %h expected 0", {o_loading, o_tap, o_sample});
        else passed++;
        i_s_valid = 1'b0; i_s_data = '0; i_coef_start = 1'b0; i_c_valid = 1'b0;
        i_reset = 1'b0;
        tick();
    endtask

    task automatic test_stream();
        int bad;
        clear_log();
        i_s_valid = 1'b1; i_s_data = 16'h0001;
        tick();
        checks++; if (o_fill !== 5'd1 || o_ce !== 1'b0)
            $display("FAIL stream_accept: got fill=%0d ce=%b expected fill=1 ce=0", o_fill, o_ce);
        else passed++;
        i_s_data = 16'h0002;
        tick();
        checks++; if (o_ce !== 1'b1 || o_sample !== 16'h0001)
            $display("FAIL stream_latency: got ce=%b sample=%h expected ce=1 sample=0001", o_ce, o_sample);
        else passed++;
        i_s_data = 16'h0003;
        tick();
        i_s_valid = 1'b0; i_s_data = '0;
        for (int i = 0; i < 400 && ce_q.size() < 3; i++) tick();
        bad = 0;
        for (int i = 0; i < 3; i++)
            if (i >= ce_q.size() || ce_q[i] !== 16'(i + 1)) bad++;
        checks++; if (bad != 0 || ce_q.size() != 3)
            $display("FAIL stream_data: got %0d strobes, %0d wrong expected 3 strobes 1,2,3", ce_q.size(), bad);
        else passed++;
        checks++; if (ce_q.size() < 3 || ce_cyc[1] - ce_cyc[0] != 111 || ce_cyc[2] - ce_cyc[1] != 111)
            $display("FAIL stream_spacing: got strobe count %0d, intervals not 111 expected 110 idle cycles", ce_q.size());
        else passed++;
        checks++; if (max_fill != 2) $display("FAIL stream_peak_fill: got %0d expected 2", max_fill); else passed++;
        checks++; if (o_fill !== 5'd0) $display("FAIL stream_drained: got %0d expected 0", o_fill); else passed++;
    endtask

    task automatic test_coef_load();
        int bad;
        idle(120);
        clear_log();
        do_load(1'b1, -1);
        checks++; if (fil_rst_n != 1) $display("FAIL load_fil_reset: got %0d pulses expected 1", fil_rst_n); else passed++;
        checks++; if (tap_q.size() != 110) $display("FAIL load_tap_count: got %0d expected 110", tap_q.size()); else passed++;
        bad = 0;
        for (int i = 0; i < tap_q.size(); i++) if (tap_q[i] !== 16'(i)) bad++;
        checks++; if (bad != 0) $display("FAIL load_tap_order: got %0d out-of-order taps expected 0", bad); else passed++;
        checks++; if (o_c_ready !== 1'b0 || o_loading !== 1'b0)
            $display("FAIL load_done_ready: got c_ready=%b loading=%b expected 0 0", o_c_ready, o_loading);
        else passed++;
        checks++; if (ce_q.size() != 0) $display("FAIL load_no_ce: got %0d strobes expected 0", ce_q.size()); else passed++;
    endtask

    task automatic test_fifo_full();
        int acc;
        int cdrv;
        int n;
        int bad;
        bit seen_first;
        logic [4:0] fill_at_first;
        logic rdy_at_first;
        clear_log();
        i_coef_start = 1'b1;
        tick();
        i_coef_start = 1'b0;
        tick();
        acc = 0;
        for (int i = 0; i < 20; i++) begin
            i_s_valid = 1'b1;
            i_s_data  = 16'h0100 + 16'(acc);
            if (o_s_ready) acc++;
            tick();
        end
        checks++; if (o_fill !== 5'd16) $display("FAIL full_fill: got %0d expected 16", o_fill); else passed++;
        checks++; if (o_s_ready !== 1'b0) $display("FAIL full_ready: got %b expected 0", o_s_ready); else passed++;
        cdrv = 0; n = 0; seen_first = 1'b0; fill_at_first = '0; rdy_at_first = 1'b0;
        while (ce_q.size() < 17 && n < 3000) begin
            i_c_valid = (cdrv < 110);
            i_c_data  = 16'(cdrv);
            if (i_c_valid && o_c_ready) cdrv++;
            i_s_valid = (acc < 17);
            i_s_data  = 16'h0100 + 16'(acc);
            if (i_s_valid && o_s_ready) acc++;
            tick();
            n++;
            if (ce_q.size() == 1 && !seen_first) begin
                seen_first = 1'b1;
                fill_at_first = o_fill;
                rdy_at_first = o_s_ready;
            end
        end
        i_c_valid = 1'b0; i_s_valid = 1'b0; i_s_data = '0;
        checks++; if (fill_at_first !== 5'd15 || rdy_at_first !== 1'b1)
            $display("FAIL full_first_pop: got fill=%0d ready=%b expected 15 1", fill_at_first, rdy_at_first);
        else passed++;
        checks++; if (ce_q.size() < 1 || ce_cyc[0] - last_tap_cyc != 3)
            $display("FAIL full_post_load_gap: got %0d strobes, last tap at %0d expected first strobe 3 cycles later", ce_q.size(), last_tap_cyc);
        else passed++;
        bad = 0;
        for (int i = 0; i < 17; i++) if (i >= ce_q.size() || ce_q[i] !== 16'h0100 + 16'(i)) bad++;
        checks++; if (bad != 0) $display("FAIL full_drain_data: got %0d wrong samples expected 0", bad); else passed++;
        bad = 0;
        for (int i = 1; i < ce_cyc.size(); i++) if (ce_cyc[i] - ce_cyc[i-1] != 111) bad++;
        checks++; if (bad != 0) $display("FAIL full_drain_spacing: got %0d bad intervals expected 0", bad); else passed++;
    endtask

    task automatic test_restart();
        int bad;
        idle(115);
        clear_log();
        i_s_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            i_s_data = 16'h0201 + 16'(i);
            tick();
        end
        i_s_valid = 1'b0; i_s_data = '0;
        checks++; if (o_fill !== 5'd3 || ce_q.size() != 1)
            $display("FAIL restart_setup: got fill=%0d strobes=%0d expected 3 1", o_fill, ce_q.size());
        else passed++;
        idle(58);
        clear_log();
        do_load(1'b1, -1);
        for (int i = 0; i < 600 && ce_q.size() < 3; i++) tick();
        checks++; if (ce_q.size() < 1 || ce_cyc[0] - last_tap_cyc != 3)
            $display("FAIL restart_no_ce_in_load: got %0d strobes, last tap at %0d expected first strobe 3 cycles later", ce_q.size(), last_tap_cyc);
        else passed++;
        bad = 0;
        for (int i = 0; i < 3; i++) if (i >= ce_q.size() || ce_q[i] !== 16'h0202 + 16'(i)) bad++;
        checks++; if (bad != 0 || ce_q.size() != 3)
            $display("FAIL restart_data: got %0d strobes, %0d wrong expected 0202..0204", ce_q.size(), bad);
        else passed++;
        checks++; if (ce_q.size() < 3 || ce_cyc[1] - ce_cyc[0] != 111 || ce_cyc[2] - ce_cyc[1] != 111)
            $display("FAIL restart_spacing: got %0d strobes with wrong intervals expected 111", ce_q.size());
        else passed++;
    endtask

    task automatic test_async_reset();
        int n;
        int bad;
        idle(115);
        clear_log();
        i_coef_start = 1'b1;
        tick();
        i_coef_start = 1'b0;
        n = 0;
        while (tap_q.size() < 40 && n < 200) begin
            i_c_valid = 1'b1;
            i_c_data  = 16'h1000 + 16'(n);
            tick();
            n++;
        end
        #2 i_reset = 1'b1;
        #1;
        checks++; if ({o_tap_wr, o_tap, o_ce, o_sample, o_fil_reset, o_loading, o_c_ready, o_fill} !== 42'b0)
            $display("FAIL async_outputs: got tap_wr=%b tap=%h loading=%b c_ready=%b fill=%0d expected all 0",
                     o_tap_wr, o_tap, o_loading, o_c_ready, o_fill);
        else passed++;
        checks++; if (o_s_ready !== 1'b1) $display("FAIL async_s_ready: got %b expected 1", o_s_ready); else passed++;
        i_c_valid = 1'b0; i_c_data = '0;
        #3 i_reset = 1'b0;
        tick();
        clear_log();
        do_load(1'b0, -1);
        bad = 0;
        for (int i = 0; i < tap_q.size(); i++) if (tap_q[i] !== 16'(i)) bad++;
        checks++; if (tap_q.size() != 110 || bad != 0 || fil_rst_n != 1)
            $display("FAIL async_reload: got taps=%0d wrong=%0d resets=%0d expected 110 0 1", tap_q.size(), bad, fil_rst_n);
        else passed++;
    endtask

    task automatic test_ignore();
        int bad;
        idle(5);
        clear_log();
        do_load(1'b1, 30);
        checks++; if (fil_rst_n != 1) $display("FAIL ignore_restart: got %0d filter resets expected 1", fil_rst_n); else passed++;
        bad = 0;
        for (int i = 0; i < tap_q.size(); i++) if (tap_q[i] !== 16'(i)) bad++;
        checks++; if (tap_q.size() != 110 || bad != 0)
            $display("FAIL ignore_taps: got %0d taps, %0d wrong expected 110 0", tap_q.size(), bad);
        else passed++;
        i_c_valid = 1'b1; i_c_data = 16'hABCD;
        idle(10);
        i_c_valid = 1'b0; i_c_data = '0;
        checks++; if (tap_q.size() != 110 || o_c_ready !== 1'b0)
            $display("FAIL ignore_run_coef: got taps=%0d c_ready=%b expected 110 0", tap_q.size(), o_c_ready);
        else passed++;
        checks++; if (o_tap !== 16'd109) $display("FAIL ignore_tap_hold: got %h expected 006d", o_tap); else passed++;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_coef_load();
        test_fifo_full();
        test_restart();
        test_async_reset();
        test_ignore();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
